nes_pad_scanner: RTL and testbench

- Parametrised serial game-pad poller; replaces the single-pad, fixed-timing NES reader.
- Drives one shared latch/nes_clk pair to NUM_PADS pads, each with its own data line.
- Supports 8-bit NES and 16-bit SNES frames through NUM_BITS.
- Publishes debounced-by-frame button vectors, one-cycle pressed/released edge pulses and a frame-done strobe to game logic.

---
 rtl/nes_pad_pkg.sv | 58 +++++
 rtl/nes_pad_scanner_sync_2ff.sv | 28 ++
 rtl/nes_pad_scanner.sv | 184 ++++++++++++++++++
 tb/tb_nes_pad_scanner.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
// Shared definitions for the serial game-pad scanner: scanner states,
// NES/SNES button bit positions and small elaboration-time helpers.
package nes_pad_pkg;

  // Scanner phases of one poll frame.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    WAIT0 = 3'd2,
    CLOCK = 3'd3,
    DONE  = 3'd4
  } scan_state_e;

  // NES controller bit order (8-bit frame).
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  // SNES controller bit order (16-bit frame, bits 12..15 reserved).
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Flat index of bit k of pad p in the published button vector.
  function automatic int pad_bit(input int p, input int k, input int nbits);
    return p * nbits + k;
  endfunction

  // Total cycles of one enabled poll frame.
  function automatic int frame_cycles(input int latch_c, input int half_c,
                                      input int nbits, input int gap_c);
    return latch_c + half_c + (nbits - 1) * 2 * half_c + 1 + gap_c;
  endfunction

endpackage

// File: rtl/nes_pad_scanner_sync_2ff.sv
// Two-flop synchroniser for the asynchronous pad data lines. Resets to all
// ones, which is the released level of an active-low pad line.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nes_pad_scanner.sv
// Multi-pad NES/SNES serial poller. One shared latch/nes_clk pair drives all
// pads; each pad returns its frame on its own data line. A completed frame is
// published as a button vector plus press/release edge pulses.
module nes_pad_scanner
  import nes_pad_pkg::*;
#(
  parameter int NUM_PADS        = 2,
  parameter int NUM_BITS        = 8,
  parameter int LATCH_CYCLES    = 1200,
  parameter int HALF_CYCLES     = 600,
  parameter int POLL_GAP_CYCLES = 16000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          data,
  output logic                         latch,
  output logic                         nes_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         frame_done
);

  localparam int FW      = NUM_PADS * NUM_BITS;
  localparam int CNT_MAX = max3(LATCH_CYCLES, 2 * HALF_CYCLES, POLL_GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  // Terminal counts for each phase (counter runs 0..N-1).
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(POLL_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_PER_LAST   = CNT_W'(2 * HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HALF       = CNT_W'(HALF_CYCLES);
  localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_BITS - 1);

  scan_state_e      r_state;
  scan_state_e      w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_sample;
  logic             w_latch_nx;
  logic             w_nclk_nx;

  logic             r_latch;
  logic             r_nes_clk;
  logic [FW-1:0]    r_shadow;
  logic [FW-1:0]    r_buttons;
  logic [FW-1:0]    r_pressed;
  logic [FW-1:0]    r_released;
  logic             r_frame_done;

  logic [NUM_PADS-1:0] w_data_sync;

  sync_2ff #(
    .WIDTH (NUM_PADS)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (data),
    .o_q     (w_data_sync)
  );

  // Next-state, counter and bit-index decode; sample strobe on period ends.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_idx_nx   = r_idx;
    w_sample   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_cnt == C_GAP_LAST) begin
          if (enable) begin
            w_state_nx = LATCH;
            w_cnt_nx   = '0;
          end else begin
            // Gap has elapsed; park here until enable returns.
            w_cnt_nx = r_cnt;
          end
        end
      end
      LATCH: begin
        if (r_cnt == C_LATCH_LAST) begin
          w_state_nx = WAIT0;
          w_cnt_nx   = '0;
        end
      end
      WAIT0: begin
        if (r_cnt == C_HALF_LAST) begin
          // Bit 0 is already on the line after latch; no clock needed.
          w_sample   = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = (NUM_BITS > 1) ? CLOCK : DONE;
          w_idx_nx   = (NUM_BITS > 1) ? IDX_W'(1) : '0;
        end
      end
      CLOCK: begin
        if (r_cnt == C_PER_LAST) begin
          w_sample = 1'b1;
          w_cnt_nx = '0;
          if (r_idx == C_IDX_LAST) begin
            w_state_nx = DONE;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
      end
    endcase
  end

  // Pin levels come from the next state so the flops line up with the phase.
  always_comb begin
    w_latch_nx = (w_state_nx == LATCH);
    w_nclk_nx  = (w_state_nx == CLOCK) && (w_cnt_nx < C_HALF);
  end

  // Sequencer state and registered pad-side pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_latch   <= 1'b0;
      r_nes_clk <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_idx     <= w_idx_nx;
      r_latch   <= w_latch_nx;
      r_nes_clk <= w_nclk_nx;
    end
  end

  // Collect the frame into the shadow register, all pads in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (w_sample) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        r_shadow[pad_bit(p, int'(r_idx), NUM_BITS)] <= ~w_data_sync[p];
      end
    end
  end

  // Publish a finished frame and its edge pulses; pulses last one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buttons    <= '0;
      r_pressed    <= '0;
      r_released   <= '0;
      r_frame_done <= 1'b0;
    end else if (r_state == DONE) begin
      r_buttons    <= r_shadow;
      r_pressed    <= r_shadow & ~r_buttons;
      r_released   <= ~r_shadow & r_buttons;
      r_frame_done <= 1'b1;
    end else begin
      r_pressed    <= '0;
      r_released   <= '0;
      r_frame_done <= 1'b0;
    end
  end

  assign latch      = r_latch;
  assign nes_clk    = r_nes_clk;
  assign buttons    = r_buttons;
  assign pressed    = r_pressed;
  assign released   = r_released;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_nes_pad_scanner.sv
// Self-checking bench for nes_pad_scanner: pad models on the serial lines, a
// frame-position reference model checked every cycle, directed scenarios with
// literal expectations, and a randomized phase.
module tb_nes_pad_scanner;

  localparam int NP    = 2;
  localparam int NB    = 8;
  localparam int NB16  = 16;
  localparam int LC    = 4;
  localparam int HC    = 3;
  localparam int GAP   = 3;
  localparam int FRAME = LC + HC + (NB - 1) * 2 * HC + 1 + GAP;   // 53
  localparam int CS    = GAP + LC + HC;                            // first CLOCK position

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;

  logic [NP-1:0]       data;
  logic                latch, nes_clk, frame_done;
  logic [NP*NB-1:0]    buttons, pressed, released;

  logic [NP-1:0]       data16;
  logic                latch16, nes_clk16, frame_done16;
  logic [NP*NB16-1:0]  buttons16, pressed16, released16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nes_pad_scanner #(
    .NUM_PADS(NP), .NUM_BITS(NB), .LATCH_CYCLES(LC),
    .HALF_CYCLES(HC), .POLL_GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data(data),
    .latch(latch), .nes_clk(nes_clk), .buttons(buttons),
    .pressed(pressed), .released(released), .frame_done(frame_done)
  );

  nes_pad_scanner #(
    .NUM_PADS(NP), .NUM_BITS(NB16), .LATCH_CYCLES(LC),
    .HALF_CYCLES(HC), .POLL_GAP_CYCLES(GAP)
  ) dut16 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data(data16),
    .latch(latch16), .nes_clk(nes_clk16), .buttons(buttons16),
    .pressed(pressed16), .released(released16), .frame_done(frame_done16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pad models (shift register loaded while latch high) ----
  logic [NP-1:0][NB-1:0]   pad_btn = '0;
  logic [NP-1:0][NB-1:0]   pad_sr  = '0;
  int                      pad_idx = 0;
  logic                    prev_nclk = 1'b0;

  always @(posedge clk) begin
    prev_nclk <= nes_clk;
    if (latch) begin
      pad_sr  <= pad_btn;
      pad_idx <= 0;
    end else if (nes_clk && !prev_nclk) begin
      pad_idx <= pad_idx + 1;
    end
  end

  always_comb begin
    data = '0;
    for (int p = 0; p < NP; p++)
      data[p] = (pad_idx < NB) ? ~pad_sr[p][pad_idx] : 1'b0;
  end

  logic [NP-1:0][NB16-1:0] pad16_btn = {16'h0000, 16'h0900};
  logic [NP-1:0][NB16-1:0] pad16_sr  = '0;
  int                      pad16_idx = 0;
  logic                    prev_nclk16 = 1'b0;

  always @(posedge clk) begin
    prev_nclk16 <= nes_clk16;
    if (latch16) begin
      pad16_sr  <= pad16_btn;
      pad16_idx <= 0;
    end else if (nes_clk16 && !prev_nclk16) begin
      pad16_idx <= pad16_idx + 1;
    end
  end

  always_comb begin
    data16 = '0;
    for (int p = 0; p < NP; p++)
      data16[p] = (pad16_idx < NB16) ? ~pad16_sr[p][pad16_idx] : 1'b0;
  end

  // ---------------- reference model: position within the frame ------------
  int               pos = 0;
  logic [NP*NB-1:0] m_snap = '0, m_btn = '0, m_prs = '0, m_rel = '0;
  logic             m_done = 1'b0;

  function automatic logic f_latch(input int ps);
    return (ps >= GAP) && (ps < GAP + LC);
  endfunction

  function automatic logic f_nclk(input int ps);
    return (ps >= CS) && (ps < FRAME - 1) && (((ps - CS) % (2 * HC)) < HC);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos = 0; m_snap = '0; m_btn = '0; m_prs = '0; m_rel = '0; m_done = 1'b0;
    end else begin
      m_prs = '0; m_rel = '0; m_done = 1'b0;
      if (f_latch(pos)) m_snap = pad_btn;
      if (pos == FRAME - 1) begin
        m_prs  = m_snap & ~m_btn;
        m_rel  = ~m_snap & m_btn;
        m_btn  = m_snap;
        m_done = 1'b1;
      end
      if (!(pos == GAP - 1 && !enable))
        pos = (pos == FRAME - 1) ? 0 : pos + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("latch",      32'(latch),      32'(f_latch(pos)));
    chk("nes_clk",    32'(nes_clk),    32'(f_nclk(pos)));
    chk("buttons",    32'(buttons),    32'(m_btn));
    chk("pressed",    32'(pressed),    32'(m_prs));
    chk("released",   32'(released),   32'(m_rel));
    chk("frame_done", 32'(frame_done), 32'(m_done));
  end

  // ---------------- directed + random stimulus -----------------------------
  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit w16, input int budget, output int n);
    n = 0;
    do begin
      wait_cycle();
      n++;
    end while (!(w16 ? frame_done16 : frame_done) && n < budget);
    if (!(w16 ? frame_done16 : frame_done)) begin
      checks++;
      failures++;
      $display("FAIL timeout_frame_done waited=%0d required<%0d", n, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, rises;
    logic prev;

    // Reset state and first-frame timing with all buttons released.
    enable  = 1'b1;
    pad_btn = '0;
    reset_n = 1'b0;
    repeat (3) wait_cycle();
    chk("rst_latch",   32'(latch),      32'h0);
    chk("rst_nclk",    32'(nes_clk),    32'h0);
    chk("rst_buttons", 32'(buttons),    32'h0);
    chk("rst_done",    32'(frame_done), 32'h0);
    reset_n = 1'b1;

    n = 0;
    do begin wait_cycle(); n++; end while (!latch && n < 20);
    chk("first_latch_delay", n, 3);
    h = 0;
    while (latch && h < 20) begin wait_cycle(); h++; end
    chk("latch_width", h, 4);
    rises = 0; prev = nes_clk; n = 0;
    do begin
      wait_cycle(); n++;
      if (nes_clk && !prev) rises++;
      prev = nes_clk;
    end while (!frame_done && n < 200);
    chk("nclk_pulses_8", rises, 7);
    chk("f1_buttons", 32'(buttons), 32'h0);
    wait_done(1'b0, 200, n);
    chk("frame_period", n, 53);

    // Pad 0 = 0x6E, pad 1 = 0x81.
    pad_btn = {8'h81, 8'h6E};
    wait_done(1'b0, 200, n);
    chk("f2_buttons", 32'(buttons), 32'h816E);
    chk("f2_pressed", 32'(pressed), 32'h816E);
    wait_cycle();
    chk("f2_pressed_1cyc", 32'(pressed), 32'h0);

    // Pad 0 releases bit 5.
    pad_btn[0] = 8'h4E;
    wait_done(1'b0, 200, n);
    chk("f3_buttons",  32'(buttons),  32'h814E);
    chk("f3_released", 32'(released), 32'h0020);
    chk("f3_pressed",  32'(pressed),  32'h0);

    // Drop enable mid-CLOCK: frame still completes, then scanner parks.
    pad_btn[1] = 8'h3C;
    n = 0;
    do begin wait_cycle(); n++; end while (!nes_clk && n < 200);
    enable = 1'b0;
    wait_done(1'b0, 200, n);
    chk("f4_buttons", 32'(buttons), 32'h3C4E);
    h = 0;
    for (int c = 0; c < 60; c++) begin wait_cycle(); if (latch) h++; end
    chk("parked_latch_cycles", h, 0);
    enable = 1'b1;
    wait_cycle();
    chk("reenable_latch", 32'(latch), 32'h1);

    // Reset at bit 4 with every button held.
    wait_done(1'b0, 200, n);
    pad_btn = '1;
    rises = 0; prev = nes_clk; n = 0;
    do begin
      wait_cycle(); n++;
      if (nes_clk && !prev) rises++;
      prev = nes_clk;
    end while (rises < 4 && n < 200);
    chk("bit4_reached", rises, 4);
    reset_n = 1'b0;
    #1;
    chk("midrst_latch", 32'(latch),   32'h0);
    chk("midrst_nclk",  32'(nes_clk), 32'h0);
    wait_cycle(); wait_cycle();
    reset_n = 1'b1;
    chk("midrst_buttons", 32'(buttons), 32'h0);
    wait_done(1'b0, 200, n);
    chk("f5_buttons", 32'(buttons), 32'hFFFF);
    chk("f5_pressed", 32'(pressed), 32'hFFFF);

    // Randomized buttons, enable and occasional resets.
    for (int c = 0; c < 800; c++) begin
      wait_cycle();
      if ($urandom_range(19) == 0) pad_btn = 16'($urandom);
      if ($urandom_range(29) == 0) enable = ($urandom_range(3) != 0);
      if ($urandom_range(399) == 0) begin
        reset_n = 1'b0;
        wait_cycle(); wait_cycle();
        reset_n = 1'b1;
      end
    end

    // 16-bit build: pad 0 holds A and R.
    enable  = 1'b1;
    reset_n = 1'b0;
    wait_cycle(); wait_cycle();
    reset_n = 1'b1;
    wait_done(1'b1, 300, n);
    chk("s16_buttons", buttons16, 32'h0000_0900);
    chk("s16_A",       32'(buttons16[8]),  32'h1);
    chk("s16_R",       32'(buttons16[11]), 32'h1);
    rises = 0; prev = nes_clk16; n = 0;
    do begin
      wait_cycle(); n++;
      if (nes_clk16 && !prev) rises++;
      prev = nes_clk16;
    end while (!frame_done16 && n < 300);
    chk("nclk_pulses_16", rises, 15);
    chk("s16_period", n, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
